// File: rtl/cpu_axi_bridge.sv
// Bridges the CPU's SRAM-like instruction and data ports onto one AXI master port.
// Only one AXI transaction is in flight at a time; requests are accepted only in IDLE.
module cpu_axi_bridge #(
  parameter int unsigned DATA_PRIO = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AWW, WR_B} state_t;

  state_t      state, state_nx;
  logic        src_data;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        aw_done, w_done;
  logic        grant_inst, grant_data;
  logic        aw_hs, w_hs;
  logic [1:0]  data_size_eff;

  // Size 3 is not a legal CPU size; it is carried as a word access.
  assign data_size_eff = (data_size == 2'd3) ? 2'd2 : data_size;

  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (resetn && state == IDLE) begin
      if (DATA_PRIO != 0) begin
        grant_data = data_req;
        grant_inst = inst_req && !data_req;
      end else begin
        grant_inst = inst_req;
        grant_data = data_req && !inst_req;
      end
    end
  end

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (grant_data)      state_nx = data_wr ? WR_AWW : RD_AR;
        else if (grant_inst) state_nx = RD_AR;
      end
      RD_AR:   if (arready) state_nx = RD_R;
      RD_R:    if (rvalid)  state_nx = IDLE;
      WR_AWW:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_nx = WR_B;
      WR_B:    if (bvalid)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      src_data  <= 1'b0;
      lat_size  <= 2'd0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant_data) begin
        src_data  <= 1'b1;
        lat_size  <= data_size_eff;
        lat_addr  <= data_addr;
        lat_wdata <= data_wdata;
      end else if (grant_inst) begin
        src_data  <= 1'b0;
        lat_size  <= 2'd2;
        lat_addr  <= inst_addr;
        lat_wdata <= '0;
      end
      // Handshake flags live only while both AW and W are still being collected.
      if (state == WR_AWW && state_nx == WR_AWW) begin
        aw_done <= aw_done | aw_hs;
        w_done  <= w_done | w_hs;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

  always_comb begin
    case (lat_size)
      2'd0:    wstrb = 4'b0001 << lat_addr[1:0];
      2'd1:    wstrb = lat_addr[1] ? 4'b1100 : 4'b0011;
      default: wstrb = 4'b1111;
    endcase
  end

  assign araddr  = lat_addr;
  assign awaddr  = lat_addr;
  assign arsize  = {1'b0, lat_size};
  assign awsize  = {1'b0, lat_size};
  assign wdata   = lat_wdata;

  assign arvalid = (state == RD_AR);
  assign rready  = (state == RD_R);
  assign awvalid = (state == WR_AWW) && !aw_done;
  assign wvalid  = (state == WR_AWW) && !w_done;
  assign bready  = (state == WR_B);

  assign inst_data_ok = resetn && (state == RD_R) && rvalid && !src_data;
  assign data_data_ok = resetn && (((state == RD_R) && rvalid && src_data) ||
                                   ((state == WR_B) && bvalid));
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Randomised scoreboard bench for cpu_axi_bridge: CPU masters, AXI slave with a byte memory,
// and an independent reference memory that predicts every AXI beat and every returned word.
module tb_cpu_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0]  arsize, awsize;
  logic [3:0]  wstrb;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;

  cpu_axi_bridge #(.DATA_PRIO(1)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_data;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  axsize;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_ref   [logic [29:0]];
  logic [31:0] slave_mem [logic [29:0]];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit busy = 0;
  int last_dok_cyc = -100, ar_hs_cyc = -100, aw_hs_cyc = -100, w_hs_cyc = -100, grant_cyc = -100;

  int ar_delay = 0, aw_delay = 0, w_delay = 0, r_delay = 0, b_delay = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] bgWord(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    return mem_ref.exists(a[31:2]) ? mem_ref[a[31:2]] : bgWord(a);
  endfunction

  function automatic logic [31:0] slaveRead(input logic [31:0] a);
    return slave_mem.exists(a[31:2]) ? slave_mem[a[31:2]] : bgWord(a);
  endfunction

  // Reference: builds the expected AXI beat and response from the CPU-level request.
  function automatic exp_t buildExpect(input bit is_data, input bit wr, input logic [1:0] size,
                                       input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int n, off;
    logic [31:0] w;
    logic [1:0] sz;
    sz = (!is_data || size == 2'd3) ? 2'd2 : size;
    n = 1 << sz;
    off = (sz == 2'd0) ? int'(a[1:0]) : (sz == 2'd1) ? 2 * int'(a[1]) : 0;
    e.is_data = is_data;
    e.wr = is_data && wr;
    e.addr = a;
    e.axsize = {1'b0, sz};
    e.strb = 4'b0000;
    e.wdata = wd;
    e.rdata = refRead(a);
    if (e.wr) begin
      w = refRead(a);
      for (int i = off; i < off + n; i++) begin
        e.strb[i] = 1'b1;
        w[8*i +: 8] = wd[8*i +: 8];
      end
      mem_ref[a[31:2]] = w;
    end
    return e;
  endfunction

  // CPU-side master: raise req, hold it until addr_ok, then record the expectation.
  task automatic applyStimulus(input bit is_data, input bit wr, input logic [1:0] size,
                               input logic [31:0] a, input logic [31:0] wd, output int acc);
    bit got = 0;
    acc = -1;
    @(posedge clk); #1;
    if (is_data) begin
      data_req = 1; data_wr = wr; data_size = size; data_addr = a; data_wdata = wd;
    end else begin
      inst_req = 1; inst_addr = a;
    end
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (is_data ? data_addr_ok : inst_addr_ok) begin
        got = 1;
        acc = cyc;
        exp_q.push_back(buildExpect(is_data, wr, size, a, wd));
      end
    end
    if (!got) reportTimeout(is_data ? "data_grant" : "inst_grant");
    @(posedge clk); #1;
    if (is_data) data_req = 0; else inst_req = 0;
  endtask

  task automatic drain(input string name);
    bit done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      done = !busy && exp_q.size() == 0;
    end
    if (!done) reportTimeout(name);
  endtask

  // AXI slave: ready after a programmable wait, responses after a programmable delay.
  initial begin : slave
    bit s_rst, ar_hs, aw_hs, w_hs, r_hs, b_hs, arv, awv, wv;
    bit rd_pend, aw_got, w_got, b_pend;
    int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
    logic [31:0] rd_addr, wr_addr, s_araddr, s_awaddr, s_wdata, wr_data;
    logic [3:0]  s_wstrb, wr_strb;
    logic [31:0] w;
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0; rdata = 0;
    rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
    rd_addr = 0; wr_addr = 0; wr_data = 0; wr_strb = 0;
    forever begin
      @(negedge clk);
      s_rst = !resetn;
      ar_hs = arvalid && arready; aw_hs = awvalid && awready; w_hs = wvalid && wready;
      r_hs = rvalid && rready;    b_hs = bvalid && bready;
      arv = arvalid; awv = awvalid; wv = wvalid;
      s_araddr = araddr; s_awaddr = awaddr; s_wdata = wdata; s_wstrb = wstrb;
      @(posedge clk); #1;
      if (s_rst) begin
        rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
        rvalid = 0; bvalid = 0;
      end else begin
        if (ar_hs) begin rd_pend = 1; rd_addr = s_araddr; r_cnt = 0; ar_cnt = 0; end
        else if (arv) ar_cnt++;
        if (aw_hs) begin aw_got = 1; wr_addr = s_awaddr; aw_cnt = 0; end
        else if (awv) aw_cnt++;
        if (w_hs) begin w_got = 1; wr_data = s_wdata; wr_strb = s_wstrb; w_cnt = 0; end
        else if (wv) w_cnt++;
        if (r_hs) begin rvalid = 0; rd_pend = 0; end
        if (rd_pend && !rvalid) begin
          if (r_cnt >= r_delay) begin rvalid = 1; rdata = slaveRead(rd_addr); end
          else r_cnt++;
        end
        if (b_hs) bvalid = 0;
        if (aw_got && w_got) begin
          w = slaveRead(wr_addr);
          for (int i = 0; i < 4; i++) if (wr_strb[i]) w[8*i +: 8] = wr_data[8*i +: 8];
          slave_mem[wr_addr[31:2]] = w;
          aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
        end
        if (b_pend && !bvalid) begin
          if (b_cnt >= b_delay) begin bvalid = 1; b_pend = 0; end
          else b_cnt++;
        end
      end
      arready = (ar_cnt >= ar_delay);
      awready = (aw_cnt >= aw_delay);
      wready  = (w_cnt >= w_delay);
    end
  end

  // Monitor: grant rule, AXI beats against the scoreboard head, stability, responses.
  initial begin : monitor
    bit aw_seen = 0, w_seen = 0;
    bit p_arv = 0, p_arr = 0, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_rr = 0, p_br = 0;
    logic [34:0] p_ar = 0, p_aw = 0;
    logic [35:0] p_w = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn !== 1'b1) begin
        if (resetn === 1'b0)
          checkOutput("reset_oks", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
        exp_q.delete();
        busy = 0; aw_seen = 0; w_seen = 0;
        p_arv = 0; p_awv = 0; p_wv = 0; p_rr = 0; p_br = 0;
        continue;
      end
      if (inst_req || data_req || inst_addr_ok || data_addr_ok)
        checkOutput("grant", {inst_addr_ok, data_addr_ok},
                    {!busy && inst_req && !data_req, !busy && data_req});
      if (inst_addr_ok || data_addr_ok) begin busy = 1; grant_cyc = cyc; end
      if (p_arv && !p_arr) checkOutput("ar_stable", {arvalid, arsize, araddr}, {1'b1, p_ar});
      if (p_awv && !p_awr) checkOutput("aw_stable", {awvalid, awsize, awaddr}, {1'b1, p_aw});
      if (p_wv && !p_wr)   checkOutput("w_stable", {wvalid, wstrb, wdata}, {1'b1, p_w});
      if (arvalid && !p_arv) checkOutput("ar_start", cyc, grant_cyc + 1);
      if (awvalid && !p_awv && !aw_seen) checkOutput("aw_start", cyc, grant_cyc + 1);
      if (awvalid && aw_seen) checkOutput("aw_revalid", awvalid, 0);
      if (wvalid && w_seen)   checkOutput("w_revalid", wvalid, 0);
      if (exp_q.size() != 0) e = exp_q[0];
      if (arvalid && arready) begin
        ar_hs_cyc = cyc;
        if (exp_q.size() == 0) reportTimeout("ar_unexpected");
        else checkOutput("ar_beat", {e.wr, arsize, araddr}, {1'b0, e.axsize, e.addr});
      end
      if (awvalid && awready) begin
        aw_hs_cyc = cyc; aw_seen = 1;
        if (exp_q.size() == 0) reportTimeout("aw_unexpected");
        else checkOutput("aw_beat", {e.wr, awsize, awaddr}, {1'b1, e.axsize, e.addr});
      end
      if (wvalid && wready) begin
        w_hs_cyc = cyc; w_seen = 1;
        if (exp_q.size() == 0) reportTimeout("w_unexpected");
        else checkOutput("w_beat", {wstrb, wdata}, {e.strb, e.wdata});
      end
      if (rready && !p_rr) checkOutput("r_start", cyc, ar_hs_cyc + 1);
      if (bready && !p_br) begin
        checkOutput("b_after_aw_w", {aw_seen, w_seen}, 2'b11);
        checkOutput("b_start", cyc, ((aw_hs_cyc > w_hs_cyc) ? aw_hs_cyc : w_hs_cyc) + 1);
      end
      if (inst_data_ok || data_data_ok) begin
        if (exp_q.size() == 0) reportTimeout("data_ok_unexpected");
        else begin
          e = exp_q.pop_front();
          checkOutput("ok_source", {inst_data_ok, data_data_ok}, e.is_data ? 2'b01 : 2'b10);
          if (!e.wr)
            checkOutput("rdata", e.is_data ? data_rdata : inst_rdata, e.rdata);
        end
        busy = 0; aw_seen = 0; w_seen = 0; last_dok_cyc = cyc;
      end
      p_arv = arvalid; p_arr = arready; p_ar = {arsize, araddr};
      p_awv = awvalid; p_awr = awready; p_aw = {awsize, awaddr};
      p_wv = wvalid;   p_wr = wready;   p_w = {wstrb, wdata};
      p_rr = rready;   p_br = bready;
    end
  end

  task automatic setDelays(input int ar, input int aw, input int wd, input int r, input int b);
    ar_delay = ar; aw_delay = aw; w_delay = wd; r_delay = r; b_delay = b;
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int acc_i, acc_d, dummy, mode, waitc;
    bit  got;
    logic [31:0] a;
    logic [1:0]  sz;
    resetn = 0; inst_req = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    mem_ref[30'h2FF0_0000] = 32'h3C01_0001;
    slave_mem[30'h2FF0_0000] = 32'h3C01_0001;
    repeat (3) @(posedge clk);
    #1 resetn = 1;
    @(negedge clk);
    checkOutput("reset_axi", {arvalid, awvalid, wvalid, rready, bready}, 0);

    $display("[TB] boot fetch with zero-wait slave");
    setDelays(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 2'd2, 32'hBFC0_0000, 0, acc_i);
    drain("t1_drain");
    checkOutput("t1_ar_cycle", ar_hs_cyc - acc_i, 1);
    checkOutput("t1_latency", last_dok_cyc - acc_i, 2);

    $display("[TB] simultaneous inst and data read");
    fork
      applyStimulus(0, 0, 2'd2, 32'h0000_1004, 0, acc_i);
      applyStimulus(1, 0, 2'd2, 32'h0000_1008, 0, acc_d);
    join
    checkOutput("t2_data_first", acc_d < acc_i, 1);
    checkOutput("t2_inst_after_dok", acc_i, last_dok_cyc + 1);
    drain("t2_drain");

    $display("[TB] byte write with late awready");
    setDelays(0, 3, 0, 0, 0);
    applyStimulus(1, 1, 2'd0, 32'h1FC0_0003, 32'hAB00_0000, dummy);
    drain("t3_drain");
    checkOutput("t3_aw_late", aw_hs_cyc - w_hs_cyc, 3);

    $display("[TB] half write with joint handshake");
    setDelays(0, 0, 0, 0, 1);
    applyStimulus(1, 1, 2'd1, 32'h1FC0_0002, 32'h1234_5678, dummy);
    drain("t4_drain");
    checkOutput("t4_same_cycle", aw_hs_cyc, w_hs_cyc);
    applyStimulus(1, 0, 2'd2, 32'h1FC0_0000, 0, dummy);
    drain("t4_readback");

    $display("[TB] stalled arready with a waiting data requester");
    setDelays(5, 0, 0, 0, 0);
    fork
      applyStimulus(0, 0, 2'd2, 32'h0000_1010, 0, acc_i);
      begin
        @(posedge clk); @(posedge clk);
        applyStimulus(1, 0, 2'd3, 32'h0000_1014, 0, acc_d);
      end
    join
    checkOutput("t5_ar_wait", ar_hs_cyc - acc_i, 6);
    drain("t5_drain");

    $display("[TB] reset while waiting for R");
    setDelays(0, 0, 0, 1000, 0);
    applyStimulus(0, 0, 2'd2, 32'h0000_1020, 0, dummy);
    got = 0;
    for (waitc = 0; waitc < 50 && !got; waitc++) begin
      @(negedge clk);
      got = rready;
    end
    if (!got) reportTimeout("t6_rready");
    @(posedge clk); #1 resetn = 0;
    @(posedge clk); #1 resetn = 1;
    @(negedge clk);
    checkOutput("t6_axi_idle", {arvalid, awvalid, wvalid, rready, bready}, 0);
    checkOutput("t6_no_ok", {inst_data_ok, data_data_ok}, 0);
    setDelays(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 2'd2, 32'h0000_1024, 0, dummy);
    drain("t6_after_reset");

    $display("[TB] randomised traffic");
    for (int it = 0; it < 150; it++) begin
      setDelays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 2));
      mode = $urandom_range(0, 2);
      sz = 2'($urandom_range(0, 3));
      a = 32'h0000_1000 + ($urandom_range(0, 15) << 2);
      if (sz == 2'd0) a[1:0] = 2'($urandom_range(0, 3));
      if (sz == 2'd1) a[1] = 1'($urandom_range(0, 1));
      case (mode)
        0: applyStimulus(0, 0, 2'd2, 32'h0000_1000 + ($urandom_range(0, 15) << 2), 0, dummy);
        1: applyStimulus(1, 1'($urandom_range(0, 1)), sz, a, $urandom, dummy);
        default: fork
          applyStimulus(0, 0, 2'd2, 32'h0000_1000 + ($urandom_range(0, 15) << 2), 0, acc_i);
          applyStimulus(1, 1'($urandom_range(0, 1)), sz, a, $urandom, acc_d);
        join
      endcase
      if ($urandom_range(0, 1) == 1) drain("rand_drain");
    end
    drain("final_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_axi_bridge.md
Name: cpu_axi_bridge

Overview:
- Sits directly downstream of the CPU top. Converts its instruction and data SRAM-like request ports into a single AXI master port.
- Allows exactly one AXI transaction in flight. This is a read (AR→R) or a write (AW+W→B).
- Arbitrates between instruction and data requests, with fixed priority.
- AXI constants (len=0, burst=INCR, lock/cache/prot=0, ids=0) are tied by the SoC wrapper and are not ported.

Parameters:
- DATA_PRIO, 1, 1 = data request wins over instruction request when both are pending in IDLE; 0 = instruction wins.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- inst_req  in  1  instruction read request
- inst_addr  in  32  instruction byte address
- inst_addr_ok  out  1  instruction request accepted this cycle
- inst_data_ok  out  1  instruction read data valid this cycle
- inst_rdata  out  32  instruction read data
- data_req  in  1  data request
- data_wr  in  1  1 = write, 0 = read
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_addr  in  32  data byte address
- data_wdata  in  32  write data, lane-aligned
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  data read data valid, or write complete
- data_rdata  out  32  data read data
- araddr  out  32  AR address
- arsize  out  3  AR size
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rdata  in  32  R data
- rvalid  in  1  R valid
- rready  out  1  R ready
- awaddr  out  32  AW address
- awsize  out  3  AW size
- awvalid  out  1  AW valid
- awready  in  1  AW ready
- wdata  out  32  W data
- wstrb  out  4  W byte strobes
- wvalid  out  1  W valid (wlast tied to 1 by the wrapper)
- wready  in  1  W ready
- bvalid  in  1  B valid
- bready  out  1  B ready

Behaviour:

Reset
- resetn sampled low at a posedge puts state in IDLE.
- All of arvalid/awvalid/wvalid/rready/bready go to 0.
- aw_done/w_done and the latched request registers clear.
- addr_ok and data_ok are forced to 0 while resetn is low.
- Any AXI transaction in flight is abandoned; the system resets jointly.

States
- IDLE, RD_AR, RD_R, WR_AWW, WR_B.

IDLE
- Grant the winner per DATA_PRIO.
- The winner's addr_ok = req (combinational, same cycle). The loser's addr_ok = 0.
- On grant, latch source (inst/data), wr, size, addr and wdata.
- Instruction requests are always word reads.
- Next state is RD_AR if a read was granted, WR_AWW if a write was granted.

RD_AR
- arvalid = 1, holding the latched araddr/arsize.
- Go to RD_R on arready.

RD_R
- rready = 1.
- On rvalid, pulse the source's data_ok for one cycle, with rdata passed through combinationally. Then go to IDLE.

WR_AWW
- awvalid and wvalid are both asserted on entry.
- Each deasserts after its own handshake; record this in aw_done/w_done.
- Go to WR_B when both handshakes are done. This includes the case where both complete in the same cycle, or where one is already done and the other completes now.

WR_B
- bready = 1.
- On bvalid, pulse data_data_ok and go to IDLE.

Size and strobe rules
- arsize/awsize = {1'b0, size}. size 3 is treated as word.
- wstrb:
  - byte: 4'b0001 << addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- Addresses pass through unmodified.

AXI stability
- Address, data and strobe outputs are held stable while valid is high and ready is low.

Timing and throughput
- A new addr_ok is possible only in IDLE, so the earliest is the cycle after data_ok.
- Minimum read latency: addr_ok at cycle 0, arvalid at cycle 1 (arready the same cycle), data_ok at cycle 2 (rvalid the same cycle).

Other rules
- A request that drops before it is granted is simply not served.
- A requester whose req stays high while the bridge is busy sees addr_ok = 0 until the bridge returns to IDLE.

Test Plan:
1. inst_req=1, addr=0xBFC00000; arready=1 and rvalid=1 with rdata=0x3C010001 on first opportunity → inst_addr_ok at cycle 0, araddr=0xBFC00000, arsize=2, inst_data_ok + inst_rdata=0x3C010001 at cycle 2.
2. inst_req and data_req (read) both high in IDLE, DATA_PRIO=1 → data_addr_ok=1, inst_addr_ok=0. The instruction is granted in the IDLE cycle after data_data_ok.
3. Data byte write, addr=0x1FC00003, wdata=0xAB000000; awready delayed 3 cycles, wready immediate → wstrb=0001<<3=4'b1000, awsize=0. wvalid drops after 1 cycle; awvalid is held with a stable address until awready. bready rises only after both handshakes; data_data_ok pulses on bvalid.
4. Half write at addr=0x...2 with awready and wready in the same cycle → wstrb=4'b1100, direct move to WR_B.
5. arready held low 5 cycles → araddr/arvalid stable all 5 cycles. No second addr_ok appears while a requester keeps req high.
6. resetn driven low while in RD_R (rvalid never returned) → next cycle state is IDLE, all valid/ready are 0, no data_ok. A request after resetn rises is granted normally.
